// File: rtl/ntt_butterfly_q12289_pkg.sv
// Shared definitions for the q = 12289 NTT datapath.
// Modulus, coefficient width, mode encodings and modular add/sub helpers.
package ntt_butterfly_q12289_pkg;

    localparam int V = 14;
    localparam logic [V-1:0] Q = 14'd12289;

    typedef enum logic {
        MODE_CT = 1'b0,
        MODE_GS = 1'b1
    } mode_t;

    // Stage-1 bundle: CT keeps {a, t}; GS keeps {a+b, a-b, w}.
    typedef struct packed {
        mode_t          mode;
        logic           last;
        logic [V-1:0]   p0;
        logic [V-1:0]   p1;
        logic [V-1:0]   w;
    } s1_t;

    // Fold a raw 14-bit value into [0, Q); one subtract suffices since 2^14 < 2Q.
    function automatic logic [V-1:0] mod_red(input logic [V-1:0] a);
        return (a >= Q) ? a - Q : a;
    endfunction

    function automatic logic [V-1:0] mod_add(input logic [V-1:0] a,
                                             input logic [V-1:0] b);
        logic [V:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, Q})
            s = s - {1'b0, Q};
        return V'(s);
    endfunction

    // 15-bit two's-complement difference; the sign bit selects the +Q fixup.
    function automatic logic [V-1:0] mod_sub(input logic [V-1:0] a,
                                             input logic [V-1:0] b);
        logic [V:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[V])
            d = d + {1'b0, Q};
        return V'(d);
    endfunction

endpackage

// File: rtl/ntt_butterfly_q12289_mul.sv
// Combinational 14x14 modular multiplier, result always < Q.
// Barrett reduction with a tool-computed constant and two final corrections.
module mod_mul_q12289
    import ntt_butterfly_q12289_pkg::*;
(
    input  logic [V-1:0] a,
    input  logic [V-1:0] b,
    output logic [V-1:0] p
);

    localparam int          K = 42;
    localparam logic [63:0] M = (64'd1 << K) / 64'(Q);

    logic [63:0] prod;
    logic [63:0] wide;
    logic [63:0] quo;
    logic [63:0] rem;

    // Estimate floor(prod / Q) then correct the remainder into [0, Q).
    always_comb begin
        prod = 64'({14'b0, a} * {14'b0, b});
        wide = prod * M;
        quo  = wide >> K;
        rem  = prod - quo * 64'(Q);
        if (rem >= 64'(Q))
            rem = rem - 64'(Q);
        if (rem >= 64'(Q))
            rem = rem - 64'(Q);
        p = V'(rem);
    end

endmodule

// File: rtl/ntt_butterfly_q12289.sv
// Two-stage pipelined radix-2 NTT butterfly over Z_12289.
// CT or GS selected per transaction; valid/ready with full-rate skid-free stall.
module ntt_butterfly_q12289
    import ntt_butterfly_q12289_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic         in_last,
    input  logic [V-1:0] in_a,
    input  logic [V-1:0] in_b,
    input  logic [V-1:0] in_w,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [V-1:0] out_x,
    output logic [V-1:0] out_y,
    output logic         out_last,
    output logic         err
);

    logic         v1;
    logic         v2;
    logic         en1;
    logic         en2;
    logic         accept;
    logic         bad;
    mode_t        mode_in;
    logic [V-1:0] a_r;
    logic [V-1:0] b_r;
    logic [V-1:0] t;
    logic [V-1:0] gs_y;
    logic [V-1:0] x_d;
    logic [V-1:0] y_d;
    s1_t          s1;
    s1_t          s1_d;

    assign en2       = ~v2 | out_ready;
    assign en1       = ~v1 | en2;
    assign in_ready  = en1;
    assign accept    = in_valid & en1;
    assign out_valid = v2;
    assign mode_in   = mode_t'(in_mode);

    // Out-of-range operands are folded so results stay < Q even when err fires.
    assign a_r = mod_red(in_a);
    assign b_r = mod_red(in_b);
    assign bad = (in_a >= Q) | (in_b >= Q) | (in_w >= Q);

    mod_mul_q12289 u_mul_ct (
        .a (in_w),
        .b (b_r),
        .p (t)
    );

    // Build the stage-1 bundle for the incoming transaction's mode.
    always_comb begin
        s1_d      = '0;
        s1_d.mode = mode_in;
        s1_d.last = in_last;
        unique case (mode_in)
            MODE_CT: begin
                s1_d.p0 = a_r;
                s1_d.p1 = t;
            end
            MODE_GS: begin
                s1_d.p0 = mod_add(a_r, b_r);
                s1_d.p1 = mod_sub(a_r, b_r);
                s1_d.w  = in_w;
            end
        endcase
    end

    // Stage 1 register: loads whenever it can hand off or is empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            s1 <= '0;
        end else if (en1) begin
            v1 <= accept;
            s1 <= s1_d;
        end
    end

    mod_mul_q12289 u_mul_gs (
        .a (s1.p1),
        .b (s1.w),
        .p (gs_y)
    );

    // Stage-2 results: CT add/sub of a and t, GS passes the sum and scales the difference.
    always_comb begin
        x_d = s1.p0;
        y_d = gs_y;
        if (s1.mode == MODE_CT) begin
            x_d = mod_add(s1.p0, s1.p1);
            y_d = mod_sub(s1.p0, s1.p1);
        end
    end

    // Stage 2 register: holds outputs stable while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2       <= 1'b0;
            out_x    <= '0;
            out_y    <= '0;
            out_last <= 1'b0;
        end else if (en2) begin
            v2       <= v1;
            out_x    <= x_d;
            out_y    <= y_d;
            out_last <= s1.last;
        end
    end

    // Sticky range error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n)
            err <= 1'b0;
        else if (accept & bad)
            err <= 1'b1;
    end

endmodule

// File: tb/tb_ntt_butterfly_q12289.sv
// Directed and randomized self-checking bench for ntt_butterfly_q12289.
// Expected results come from hand-computed vectors and an integer reference model.
module tb_ntt_butterfly_q12289;
    import ntt_butterfly_q12289_pkg::*;

    localparam int QI = 12289;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic         in_last;
    logic [V-1:0] in_a;
    logic [V-1:0] in_b;
    logic [V-1:0] in_w;
    logic         out_valid;
    logic         out_ready;
    logic [V-1:0] out_x;
    logic [V-1:0] out_y;
    logic         out_last;
    logic         err;

    int n_tests = 0;
    int n_fail  = 0;
    bit rnd_bp  = 1'b0;

    typedef struct {
        int x;
        int y;
        bit last;
        bit care;
    } exp_t;

    exp_t exq[$];
    exp_t mon_e;

    int bm[4] = '{0, 1, 0, 1};
    int ba[4] = '{5, 100, 10, 7};
    int bb[4] = '{3, 200, 4, 2};
    int bw[4] = '{2, 3, 5, 4};
    int bx[4] = '{11, 300, 30, 9};
    int by[4] = '{12288, 11989, 12279, 20};
    int bl[4] = '{0, 0, 0, 1};

    always #5 clk = ~clk;

    ntt_butterfly_q12289 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_last  (out_last),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model(input bit mode, input int a, input int b,
                                  input int w, output int x, output int y);
        int t;
        int d;
        if (!mode) begin
            t = (w * b) % QI;
            x = (a + t) % QI;
            y = (a - t + QI) % QI;
        end else begin
            x = (a + b) % QI;
            d = (a - b + QI) % QI;
            y = (d * w) % QI;
        end
    endfunction

    task automatic set_in(input bit mode, input bit last, input int a,
                          input int b, input int w);
        in_valid = 1'b1;
        in_mode  = mode;
        in_last  = last;
        in_a     = V'(a);
        in_b     = V'(b);
        in_w     = V'(w);
    endtask

    task automatic send(input bit mode, input bit last, input int a,
                        input int b, input int w, input int ex,
                        input int ey, input bit care);
        int n;
        n = 0;
        set_in(mode, last, a, b, w);
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready)
            chk("accept_timeout", 32'(in_ready), 32'd1);
        else
            exq.push_back('{ex, ey, last, care});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exq.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(exq.size()), 32'd0);
    endtask

    // Scoreboard: compare every output transfer against the queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exq.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                mon_e = exq.pop_front();
                if (mon_e.care) begin
                    chk("out_x", 32'(out_x), 32'(mon_e.x));
                    chk("out_y", 32'(out_y), 32'(mon_e.y));
                    chk("out_last", 32'(out_last), 32'(mon_e.last));
                end
            end
        end
    end

    // Random downstream backpressure during the long randomized run.
    always @(posedge clk) begin
        if (rnd_bp) begin
            #1;
            out_ready = ($urandom_range(3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx;
        int rx;
        int ry;
        int ra;
        int rb;
        int rw;
        bit rm;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_last   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_w      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_x", 32'(out_x), 32'd0);
        chk("rst_out_y", 32'(out_y), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        send(1'b0, 1'b0, 5, 3, 2, 11, 12288, 1'b1);
        chk("lat_cycle1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_cycle2", 32'(out_valid), 32'd1);
        drain();

        send(1'b0, 1'b0, 12288, 1, 1, 0, 12287, 1'b1);
        send(1'b0, 1'b1, 0, 12288, 12288, 1, 12288, 1'b1);
        drain();

        send(1'b1, 1'b0, 100, 200, 3, 300, 11989, 1'b1);
        send(1'b0, 1'b0, 5, 3, 2, 11, 12288, 1'b1);
        drain();

        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            set_in(bm[idx][0], bl[idx][0], ba[idx], bb[idx], bw[idx]);
            @(negedge clk);
            if (c >= 2) begin
                chk("bp_hold_x", 32'(out_x), 32'(bx[0]));
                chk("bp_hold_y", 32'(out_y), 32'(by[0]));
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
            end
            if (in_ready) begin
                exq.push_back('{bx[idx], by[idx], bl[idx][0], 1'b1});
                idx++;
            end
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_simul_ready", 32'(in_ready), 32'd1);
        if (in_ready) begin
            exq.push_back('{bx[idx], by[idx], bl[idx][0], 1'b1});
            idx++;
        end
        @(posedge clk);
        #1;
        while (idx < 4) begin
            send(bm[idx][0], bl[idx][0], ba[idx], bb[idx], bw[idx],
                 bx[idx], by[idx], 1'b1);
            idx++;
        end
        drain();

        send(1'b0, 1'b0, 12289, 1, 1, 0, 0, 1'b0);
        chk("err_set", 32'(err), 32'd1);
        send(1'b1, 1'b0, 100, 200, 3, 300, 11989, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("err_sticky", 32'(err), 32'd1);
        drain();

        out_ready = 1'b0;
        send(1'b0, 1'b0, 5, 3, 2, 11, 12288, 1'b1);
        send(1'b1, 1'b1, 100, 200, 3, 300, 11989, 1'b1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exq.delete();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_x", 32'(out_x), 32'd0);
        chk("mid_rst_y", 32'(out_y), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale", 32'(out_valid), 32'd0);

        rnd_bp = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            rm = 1'($urandom_range(1));
            ra = int'($urandom_range(QI - 1));
            rb = int'($urandom_range(QI - 1));
            rw = int'($urandom_range(QI - 1));
            model(rm, ra, rb, rw, rx, ry);
            send(rm, 1'($urandom_range(1)), ra, rb, rw, rx, ry, 1'b1);
        end
        rnd_bp = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        chk("rand_err_clear", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
